ahb_master_controller: RTL and testbench

AHB-Lite initiator that drives the USB AHB slave interface from a simple command/response port, so test harnesses and on-chip controllers can issue single read and write transfers.
- Each accepted command becomes one NONSEQ transfer with a registered address phase and data phase.
- Slave wait states and the two-cycle ERROR response are handled here.
- Single slave on the bus, so hsel is generated locally.

---
 rtl/usb_ahb_pkg.sv | 35 +++
 rtl/ahb_master_controller_if.sv | 44 ++++
 rtl/ahb_master_controller.sv | 100 ++++++++++
 tb/tb_ahb_master_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ahb_pkg.sv
// Shared types for the AHB-Lite initiator: bus encodings,
// FSM states and the address/data-phase pipeline entries.
package usb_ahb_pkg;

  localparam int AHB_ADDR_W = 7;
  localparam int AHB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HSIZE_BYTE = 2'b00;
  localparam logic [1:0] HSIZE_HALF = 2'b01;
  localparam logic [1:0] HSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } ahbm_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [1:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } ap_t;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [AHB_DATA_W-1:0] wdata;
  } dp_t;

endpackage

// File: rtl/ahb_master_controller_if.sv
// Command/response port plus AHB-Lite bus signals;
// master = initiator side, slave = harness/bus side.
interface ahb_master_controller_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [1:0]        hsize;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_size, cmd_wdata,
    input  hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata,
    output rsp_error, hsel, haddr, htrans,
    output hsize, hwrite, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_size, cmd_wdata,
    output hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  rsp_error, hsel, haddr, htrans,
    input  hsize, hwrite, hwdata
  );

endinterface

// File: rtl/ahb_master_controller.sv
// AHB-Lite single-transfer initiator with two-stage AP/DP pipeline.
// Define AHB_MASTER_PIPELINE_EN for overlapped address/data phases.
module ahb_master_controller
  import usb_ahb_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
) (
  input logic clk,
  input logic rst,
  ahb_master_controller_if.master bus
);

  ap_t               r_ap;
  dp_t               r_dp;
  ahbm_state_t       r_state;
  logic              r_rsp_valid;
  logic              r_rsp_error;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_adv;
  logic w_slot;
  logic w_ready;
  logic w_accept;
  logic w_done;

  assign w_adv = bus.hready && (r_state != ERR1);

`ifdef AHB_MASTER_PIPELINE_EN
  assign w_slot = !r_ap.valid || w_adv;
`else
  assign w_slot = !r_ap.valid && !r_dp.valid;
`endif

  assign w_ready  = !rst && w_slot && (r_state == RUN);
  assign w_accept = bus.cmd_valid && w_ready;
  assign w_done   = r_dp.valid && bus.hready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ap        <= '0;
      r_dp        <= '0;
      r_state     <= RUN;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        RUN: begin
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= bus.hresp;
            r_rsp_rdata <= r_dp.write ? '0 : bus.hrdata;
          end else if (r_dp.valid && bus.hresp) begin
            r_state <= ERR1;
          end
        end
        ERR1: begin
          // second error cycle: retire the failed beat, keep AP
          if (bus.hready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= 1'b1;
            r_rsp_rdata <= '0;
            r_dp.valid  <= 1'b0;
            r_state     <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
      if (w_adv) begin
        r_dp.valid <= r_ap.valid;
        r_dp.write <= r_ap.write;
        r_dp.wdata <= r_ap.wdata;
      end
      if (w_accept) begin
        r_ap.valid <= 1'b1;
        r_ap.write <= bus.cmd_write;
        r_ap.addr  <= AHB_ADDR_W'(bus.cmd_addr);
        r_ap.size  <= bus.cmd_size;
        r_ap.wdata <= AHB_DATA_W'(bus.cmd_wdata);
      end else if (w_adv) begin
        r_ap.valid <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.htrans    = (r_ap.valid && r_state == RUN)
                       ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.hsel      = (bus.htrans != HTRANS_IDLE);
  assign bus.haddr     = ADDR_W'(r_ap.addr);
  assign bus.hsize     = r_ap.size;
  assign bus.hwrite    = r_ap.write;
  assign bus.hwdata    = DATA_W'(r_dp.wdata);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_error = r_rsp_error;

endmodule

// File: tb/tb_ahb_master_controller.sv
// Scoreboard bench: directed commands, reactive slave model,
// response monitor popping expected results.
module tb_ahb_master_controller;
  import usb_ahb_pkg::*;

  typedef struct {
    int          waits;
    int          err;
    logic [31:0] rdata;
  } scfg_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_master_controller_if #(.ADDR_W(7), .DATA_W(32)) bus();

  ahb_master_controller #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  scfg_t      slv_q[$];
  exp_t       exp_q[$];
  int         rsp_cyc[$];
  logic [1:0] htr_log[int];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // reactive slave: waits, two-cycle error (err=1), one-cycle error (err=2)
  initial begin
    scfg_t cur;
    bit    act;
    bit    started;
    bit    pn;
    logic  lh;
    act = 0; started = 0; pn = 0;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 0; started = 0; pn = 0;
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
        continue;
      end
      lh = bus.hready;
      if (lh) act = 0;
      if (lh && pn) begin
        if (slv_q.size() == 0) begin
          total++; bad++;
          $display("FAIL slave_cfg: got=empty want=entry");
        end else begin
          cur = slv_q.pop_front();
          act = 1; started = 0;
        end
      end
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
      if (act) begin
        if (cur.waits > 0) begin
          bus.hready = 1'b0;
          cur.waits--;
        end else if (cur.err == 1 && !started) begin
          bus.hready = 1'b0; bus.hresp = 1'b1; started = 1;
        end else if (cur.err != 0) begin
          bus.hresp = 1'b1;
        end else begin
          bus.hrdata = cur.rdata;
        end
      end
      pn = (bus.htrans == HTRANS_NONSEQ);
    end
  end

  // response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid) begin
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got=pulse want=none");
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_error", {31'b0, bus.rsp_error}, {31'b0, e.err});
        end
      end
    end
  end

  // bus monitor: htrans must drop to IDLE after first error cycle
  initial begin
    bit ep;
    ep = 0;
    forever begin
      @(negedge clk);
      #2;
      htr_log[cyc] = bus.htrans;
      if (!rst) begin
        if (ep) check("err_idle", {30'b0, bus.htrans}, {30'b0, HTRANS_IDLE});
        ep = bus.hresp && !bus.hready;
      end else begin
        ep = 0;
      end
    end
  end

  task automatic send(input bit wr, input logic [6:0] a,
                      input logic [1:0] sz, input logic [31:0] wd,
                      input int waits, input int err,
                      input logic [31:0] rd, output int acc);
    bit    ok;
    scfg_t c;
    exp_t  ex;
    ok  = 0;
    acc = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_size  = sz;
      bus.cmd_wdata = wd;
      #1;
      if (bus.cmd_ready) begin
        c.waits = waits; c.err = err; c.rdata = rd;
        slv_q.push_back(c);
        ex.rdata = (wr || err != 0) ? 32'h0 : rd;
        ex.err   = (err != 0);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1;
        bus.cmd_valid = 1'b0;
      end
    end
    if (!ok) begin
      bus.cmd_valid = 1'b0;
      total++; bad++;
      $display("FAIL send_timeout: got=no_ready want=ready addr=%h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic at_cycle(input int c);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, g;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
    bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_htrans", bus.htrans, 0);
    check("rst_hsel", bus.hsel, 0);
    check("rst_haddr", bus.haddr, 0);
    check("rst_hsize", bus.hsize, 0);
    check("rst_hwrite", bus.hwrite, 0);
    check("rst_hwdata", bus.hwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_error", bus.rsp_error, 0);
    @(negedge clk); #2 rst = 1'b0;

    // single write, zero waits
    rsp_cyc.delete();
    send(1, 7'h10, HSIZE_WORD, 32'hDEADBEEF, 0, 0, 0, a0);
    at_cycle(a0);
    check("t1_htrans", bus.htrans, HTRANS_NONSEQ);
    check("t1_hsel", bus.hsel, 1);
    check("t1_haddr", bus.haddr, 7'h10);
    check("t1_hwrite", bus.hwrite, 1);
    check("t1_hsize", bus.hsize, HSIZE_WORD);
    at_cycle(a0 + 1);
    check("t1_hwdata", bus.hwdata, 32'hDEADBEEF);
    check("t1_idle", bus.htrans, HTRANS_IDLE);
    drain();
    check("t1_latency", rsp_cyc.size() > 0 ? rsp_cyc[0] : -1, a0 + 2);

    // read with two wait states
    rsp_cyc.delete();
    send(0, 7'h40, HSIZE_HALF, 0, 2, 0, 32'h00001234, a0);
    at_cycle(a0);
    check("t2_htrans", bus.htrans, HTRANS_NONSEQ);
    check("t2_hsize", bus.hsize, HSIZE_HALF);
    check("t2_hwrite", bus.hwrite, 0);
    at_cycle(a0 + 2);
    check("t2_hold_haddr", bus.haddr, 7'h40);
    check("t2_hold_rsp", bus.rsp_valid, 0);
    drain();
    check("t2_latency", rsp_cyc.size() > 0 ? rsp_cyc[0] : -1, a0 + 4);

    // back-to-back writes
    rsp_cyc.delete();
    send(1, 7'h00, HSIZE_WORD, 32'h11111111, 0, 0, 0, a0);
    send(1, 7'h04, HSIZE_WORD, 32'h22222222, 0, 0, 0, a1);
    send(1, 7'h08, HSIZE_WORD, 32'h33333333, 0, 0, 0, a2);
`ifdef AHB_MASTER_PIPELINE_EN
    g = 1;
`else
    g = 3;
`endif
    check("t3_gap01", a1 - a0, g);
    check("t3_gap12", a2 - a1, g);
    drain();
    check("t3_nrsp", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      check("t3_rgap01", rsp_cyc[1] - rsp_cyc[0], g);
      check("t3_rgap12", rsp_cyc[2] - rsp_cyc[1], g);
    end
`ifdef AHB_MASTER_PIPELINE_EN
    for (int k = 0; k < 3; k++)
      check("t3_nonseq", htr_log[a0 + k], HTRANS_NONSEQ);
`else
    check("t3_idle_gap", htr_log[a0 + 1], HTRANS_IDLE);
`endif

    // two-cycle ERROR on write while read is queued
    send(1, 7'h48, HSIZE_WORD, 32'hA5A50048, 0, 1, 0, a0);
    send(0, 7'h44, HSIZE_WORD, 0, 0, 0, 32'hCAFE0044, a1);
`ifdef AHB_MASTER_PIPELINE_EN
    check("t4_accept", a1 - a0, 1);
    at_cycle(a0 + 2);
    check("t4_err1_idle", bus.htrans, HTRANS_IDLE);
    check("t4_err1_hsel", bus.hsel, 0);
    at_cycle(a0 + 3);
    check("t4_reissue", bus.htrans, HTRANS_NONSEQ);
    check("t4_reissue_addr", bus.haddr, 7'h44);
    check("t4_err_rsp", bus.rsp_error, 1);
`else
    check("t4_accept", a1 - a0, 4);
`endif
    drain();

    // reset during a waited data phase
    send(1, 7'h20, HSIZE_WORD, 32'h55AA55AA, 5, 0, 0, a0);
    at_cycle(a0 + 2);
    check("t5_hwdata", bus.hwdata, 32'h55AA55AA);
    #2 rst = 1'b1;
    #1;
    check("t5_htrans", bus.htrans, 0);
    check("t5_haddr", bus.haddr, 0);
    check("t5_hwdata_rst", bus.hwdata, 0);
    check("t5_hwrite", bus.hwrite, 0);
    check("t5_cmd_ready", bus.cmd_ready, 0);
    check("t5_rsp_valid", bus.rsp_valid, 0);
    exp_q.delete();
    slv_q.delete();
    @(negedge clk);
    @(negedge clk); #2 rst = 1'b0;
    rsp_cyc.delete();
    repeat (8) @(negedge clk);
    check("t5_no_rsp", rsp_cyc.size(), 0);
    send(0, 7'h24, HSIZE_WORD, 0, 0, 0, 32'h0BADF00D, a0);
    drain();

    // hsize=11 errored by slave, then a clean write
    send(0, 7'h00, 2'b11, 0, 0, 1, 0, a0);
    at_cycle(a0);
    check("t6_hsize", bus.hsize, 2'b11);
    send(1, 7'h04, HSIZE_WORD, 32'h600D600D, 0, 0, 0, a1);
    drain();

    // one-cycle ERROR from non-compliant slave
    send(0, 7'h30, HSIZE_WORD, 0, 1, 2, 0, a0);
    send(0, 7'h34, HSIZE_BYTE, 0, 0, 0, 32'h00003434, a1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
